// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer:
// state encoding, opcode constants and datapath widths.
package cpu_sequencer_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExec    = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalt    = 3'd6,
    StInvalid = 3'd7
  } state_e;

  localparam logic [3:0] OpLw   = 4'b0000;
  localparam logic [3:0] OpSw   = 4'b0001;
  localparam logic [3:0] OpBeq  = 4'b1011;
  localparam logic [3:0] OpBne  = 4'b1100;
  localparam logic [3:0] OpNop  = 4'b1110;
  localparam logic [3:0] OpHalt = 4'b1111;

  function automatic logic is_branch(logic [3:0] op);
    return (op == OpBeq) || (op == OpBne);
  endfunction

  function automatic logic is_mem_op(logic [3:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-pc adder: pc + 1, plus the sign-extended branch offset when taken.
module pc_next
  import cpu_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] offset_i,
  input  logic            take_i,
  output logic [PC_W-1:0] next_pc_o
);

  // Offset is as wide as pc, so sign extension is the identity and the
  // modulo-256 wrap falls out of the truncating add.
  always_comb begin
    next_pc_o = pc_i + PC_W'(1) + (take_i ? offset_i : '0);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb FSM with
// handshaked memories, gated write strobes and a retired-instruction counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir,
  input  logic               dec_reg_write,
  input  logic               dec_mem_write,
  input  logic               dec_mem_to_reg,
  input  logic               branch_cond,
  output logic               dmem_req,
  input  logic               dmem_ack,
  output logic               reg_write_en,
  output logic               mem_write_en,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         state,
  output logic               halted,
  output logic [15:0]        instr_count
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [15:0]        cnt_q, cnt_d, cnt_sat;
  logic [3:0]         opcode;
  logic               take;
  logic               retire;

  assign opcode  = ir_q[15:12];
  assign take    = (state_q == StExec) && is_branch(opcode) && branch_cond;
  assign cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  pc_next u_pc_next (
    .pc_i      (pc_q),
    .offset_i  (ir_q[7:0]),
    .take_i    (take),
    .next_pc_o (pc_inc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;

    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == OpHalt)     state_d = StHalt;
        else if (opcode == OpNop) retire  = 1'b1;
        else                      state_d = StExec;
      end
      StExec: begin
        if (is_branch(opcode))      retire  = 1'b1;
        else if (is_mem_op(opcode)) state_d = StMem;
        else                        state_d = StWb;
      end
      StMem: begin
        dmem_req     = 1'b1;
        mem_write_en = dec_mem_write;
        if (dmem_ack) begin
          if (dec_mem_to_reg) state_d = StWb;
          else                retire  = 1'b1;
        end
      end
      StWb: begin
        reg_write_en = dec_reg_write;
        retire       = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // pc_inc already includes any taken-branch offset.
    if (retire) begin
      pc_d    = pc_inc;
      cnt_d   = cnt_sat;
      state_d = StFetch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ir          = ir_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign halted      = (state_q == StHalt);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: acts as instruction/data memory and
// decoder, and checks each instruction against a per-instruction reference model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req, imem_ack;
  logic [15:0] instr, ir;
  logic        dec_reg_write, dec_mem_write, dec_mem_to_reg;
  logic        branch_cond;
  logic        dmem_req, dmem_ack;
  logic        reg_write_en, mem_write_en;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] cur_word;
  logic [7:0]  pc_m;
  logic [15:0] cnt_m;
  int          n_cmp = 0;
  int          n_err = 0;

  cpu_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_req       (imem_req),
    .imem_ack       (imem_ack),
    .instr          (instr),
    .ir             (ir),
    .dec_reg_write  (dec_reg_write),
    .dec_mem_write  (dec_mem_write),
    .dec_mem_to_reg (dec_mem_to_reg),
    .branch_cond    (branch_cond),
    .dmem_req       (dmem_req),
    .dmem_ack       (dmem_ack),
    .reg_write_en   (reg_write_en),
    .mem_write_en   (mem_write_en),
    .pc             (pc),
    .state          (state),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  function automatic bit op_is_branch(logic [3:0] op);
    return (op == 4'hB) || (op == 4'hC);
  endfunction

  function automatic bit op_is_alu(logic [3:0] op);
    return !(op inside {4'h0, 4'h1, 4'hB, 4'hC, 4'hE, 4'hF});
  endfunction

  // Behavioural decoder for the word currently being executed.
  always_comb begin
    dec_mem_write  = (cur_word[15:12] == 4'h1);
    dec_mem_to_reg = (cur_word[15:12] == 4'h0);
    dec_reg_write  = op_is_alu(cur_word[15:12]) || (cur_word[15:12] == 4'h0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wrap8(int x);
    return 8'(((x % 256) + 256) % 256);
  endfunction

  function automatic int sext8(logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  task automatic retire_model(input int new_pc);
    pc_m = wrap8(new_pc);
    if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    pc_m  = 8'h00;
    cnt_m = 16'h0000;
    check_val("start_state", 32'(state), 32'd1);
    check_val("start_pc", 32'(pc), 32'(pc_m));
    check_val("start_count", 32'(instr_count), 32'(cnt_m));
  endtask

  // Feed one instruction from FETCH to its next FETCH (or HALT).
  task automatic run_instr(input logic [15:0] word, input int idelay, input int ddelay,
                           input logic bc);
    logic [3:0] op;
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    logic [2:0] st;
    int fw, mw, n_imem, n_dmem, n_rwe, n_mwe;
    bit done;
    op = word[15:12];
    cur_word = word;
    branch_cond = bc;
    fw = 0; mw = 0; n_imem = 0; n_dmem = 0; n_rwe = 0; n_mwe = 0;
    done = 1'b0;
    check_val("entry_state", 32'(state), 32'd1);
    for (int c = 0; c < 64 && !done; c++) begin
      st = state;
      got_q.push_back(st);
      n_imem += int'(imem_req);
      n_dmem += int'(dmem_req);
      n_rwe  += int'(reg_write_en);
      n_mwe  += int'(mem_write_en);
      start = 1'($urandom);
      if (st == 3'd1) begin
        imem_ack = (fw == idelay);
        instr    = imem_ack ? word : 16'($urandom);
        fw++;
      end else begin
        imem_ack = 1'($urandom);
        instr    = 16'($urandom);
      end
      if (st == 3'd4) begin
        dmem_ack = (mw == ddelay);
        mw++;
      end else begin
        dmem_ack = 1'($urandom);
      end
      step();
      if (st != 3'd1 && (state == 3'd1 || state == 3'd6)) done = 1'b1;
    end
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    if (!done) check_val("timeout", 32'd0, 32'd1);

    for (int i = 0; i <= idelay; i++) exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    if (op_is_branch(op)) begin
      exp_q.push_back(3'd3);
    end else if (op == 4'h0 || op == 4'h1) begin
      exp_q.push_back(3'd3);
      for (int i = 0; i <= ddelay; i++) exp_q.push_back(3'd4);
      if (op == 4'h0) exp_q.push_back(3'd5);
    end else if (op_is_alu(op)) begin
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd5);
    end

    check_val("trace_len", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check_val($sformatf("trace[%0d] op%0h", i, op),
                                      32'(got_q[i]), 32'(exp_q[i]));
    end
    check_val("imem_req_cycles", 32'(n_imem), 32'(idelay + 1));
    check_val("dmem_req_cycles", 32'(n_dmem), (op == 4'h0 || op == 4'h1) ? 32'(ddelay + 1) : 0);
    check_val("mem_write_cycles", 32'(n_mwe), (op == 4'h1) ? 32'(ddelay + 1) : 0);
    check_val("reg_write_cycles", 32'(n_rwe), (op_is_alu(op) || op == 4'h0) ? 32'd1 : 32'd0);

    if (op == 4'hF) begin
      // halt: pc and count untouched
    end else if (op_is_branch(op) && bc) begin
      retire_model(int'(pc_m) + 1 + sext8(word[7:0]));
    end else begin
      retire_model(int'(pc_m) + 1);
    end
    check_val("final_state", 32'(state), (op == 4'hF) ? 32'd6 : 32'd1);
    check_val("halted", 32'(halted), (op == 4'hF) ? 32'd1 : 32'd0);
    check_val("ir", 32'(ir), 32'(word));
    check_val("pc", 32'(pc), 32'(pc_m));
    check_val("instr_count", 32'(instr_count), 32'(cnt_m));
  endtask

  initial begin
    logic [3:0] alu_ops[10] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD};
    logic [3:0] op;
    logic [7:0] off;
    int r;

    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = '0; branch_cond = 1'b0; cur_word = 16'hE000;
    pc_m = '0; cnt_m = '0;
    step();
    step();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_ir", 32'(ir), 32'd0);
    check_val("rst_count", 32'(instr_count), 32'd0);
    check_val("rst_strobes", 32'({imem_req, dmem_req, reg_write_en, mem_write_en, halted}), 32'd0);
    rst_n = 1'b1;
    step();
    check_val("idle_wait", 32'(state), 32'd0);

    do_start();
    run_instr(16'h2140, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) run_instr(16'hE000, 0, 0, 1'b0);
    run_instr(16'hB0FC, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) run_instr(16'hE000, 1, 0, 1'b0);
    run_instr(16'hB0FC, 0, 0, 1'b0);
    run_instr(16'h0123, 0, 3, 1'b0);
    run_instr(16'h1234, 2, 1, 1'b0);

    // Branch to 0xFF, then a NOP wraps pc to 0.
    off = wrap8(255 - int'(pc_m) - 1);
    run_instr({8'hC0, off}, 0, 0, 1'b1);
    run_instr(16'hE000, 0, 0, 1'b0);
    run_instr(16'hF000, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      step();
      check_val("halt_hold_state", 32'(state), 32'd6);
      check_val("halt_hold_pc", 32'(pc), 32'(pc_m));
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    do_start();

    // Reset while SW waits in MEM.
    cur_word = 16'h1055;
    imem_ack = 1'b1; instr = cur_word;
    step();
    imem_ack = 1'b0;
    step();
    step();
    check_val("sw_mem_state", 32'(state), 32'd4);
    check_val("sw_mem_strobes", 32'({dmem_req, mem_write_en}), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_strobes", 32'({dmem_req, mem_write_en, reg_write_en}), 32'd0);
    check_val("async_rst_state", 32'(state), 32'd0);
    #3 rst_n = 1'b1;
    pc_m = '0; cnt_m = '0;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; instr = 16'($urandom);
      step();
      check_val("spurious_ack_state", 32'(state), 32'd0);
      check_val("spurious_ack_req", 32'({imem_req, dmem_req}), 32'd0);
      check_val("spurious_ack_pc", 32'(pc), 32'd0);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    do_start();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 2)       op = 4'hE;
      else if (r < 5)  op = (r[0]) ? 4'hB : 4'hC;
      else if (r < 8)  op = 4'h0;
      else if (r < 11) op = 4'h1;
      else if (r == 11) op = 4'hF;
      else             op = alu_ops[$urandom_range(0, 9)];
      run_instr({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));
      if (op == 4'hF) do_start();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: level, sampled in IDLE/HALT; begins execution from pc 0.
REQ-004 SHALL have ports imem_req (output, 1) / imem_ack (input, 1): instruction fetch handshake.
REQ-005 SHALL have port instr, input, 16 bits: fetched word, valid when imem_ack=1.
REQ-006 SHALL have port ir, output, 16 bits: latched instruction, feeds the decoder.
REQ-007 SHALL have ports dec_reg_write, dec_mem_write, dec_mem_to_reg; inputs, 1 bit each: decoder controls for ir.
REQ-008 SHALL have port branch_cond, input, 1 bit: ALU compare result, true = branch condition met.
REQ-009 SHALL have ports dmem_req (output, 1) / dmem_ack (input, 1): data memory handshake.
REQ-010 SHALL have ports reg_write_en, mem_write_en; outputs, 1 bit each: gated write strobes.
REQ-011 SHALL have port pc, output, 8 bits: instruction address.
REQ-012 SHALL have ports state, output, 3 bits, and halted, output, 1 bit.
REQ-013 SHALL have port instr_count, output, 16 bits: retired-instruction count.

Function
REQ-014 States SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; state 7 SHALL go to IDLE.
REQ-015 In IDLE and HALT, start=1 SHALL give pc<=0, instr_count<=0, next state FETCH.
REQ-016 FETCH SHALL drive imem_req=1 and hold pc. On an edge with imem_ack=1, ir<=instr and next state DECODE. Otherwise stay in FETCH with no timeout.
REQ-017 DECODE SHALL last 1 cycle. Opcode 4'b1111 (HALT): next HALT, halted=1, pc unchanged, not counted. Opcode 4'b1110 (NOP): retire, next FETCH. All other opcodes: next EXEC.
REQ-018 EXEC SHALL last 1 cycle. BEQ (4'b1011) and BNE (4'b1100) SHALL retire and go to FETCH. On branch_cond=1, pc<=pc+1+sext(ir[7:0]); otherwise pc<=pc+1.
REQ-019 EXEC SHALL route LW (4'b0000) and SW (4'b0001) to MEM and all other opcodes to WB.
REQ-020 MEM SHALL drive dmem_req=1 and mem_write_en=dec_mem_write until a sampled dmem_ack=1. Then SW retires to FETCH, and LW (dec_mem_to_reg=1) goes to WB.
REQ-021 WB SHALL last 1 cycle with reg_write_en=dec_reg_write, then retire and go to FETCH.
REQ-022 Retire SHALL mean: pc<=pc+1 (unless set by REQ-018) and instr_count+1, saturating at 16'hFFFF.
REQ-023 pc arithmetic SHALL be modulo 256: 8'hFF+1 wraps to 8'h00, and a negative offset below 0 wraps.
REQ-024 reg_write_en and mem_write_en SHALL be 0 outside WB and MEM respectively.
REQ-025 The block SHALL ignore imem_ack while imem_req=0, dmem_ack while dmem_req=0, and start outside IDLE/HALT.
REQ-026 Minimum cycles per instruction, with ack in the first request cycle: NOP 2, branch 3, ALU 4, SW 4, LW 5.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, pc=0, ir=0, instr_count=0, and all req/en outputs and halted=0.
REQ-028 Reset mid-transaction SHALL drop requests immediately with no write strobe issued. After release, the block SHALL wait in IDLE for start.

Structure
REQ-029 A shared package SHALL hold the state encoding, the opcode constants (including NOP 4'b1110 and HALT 4'b1111), PC_W=8 and INSTR_W=16.
REQ-030 Next-pc computation SHALL live in sub-module pc_next (pc, offset, take -> next pc), purely combinational.

Verification
REQ-031 Reset, start, fetch ADD (16'h2_1_40) with ack in the same cycle -> states 1,2,3,5,1; reg_write_en pulses 1 cycle; pc=1; instr_count=1.
REQ-032 BEQ at pc=5, ir[7:0]=8'hFC, branch_cond=1 -> pc=2. Same with branch_cond=0 -> pc=6. Neither asserts reg_write_en.
REQ-033 LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, then WB with reg_write_en=1. SW -> mem_write_en high with dmem_req, no WB state.
REQ-034 NOP at pc=8'hFF -> pc=8'h00. HALT -> halted=1 and pc frozen. start=1 then -> pc=0, instr_count=0, FETCH.
REQ-035 rst_n low during MEM of SW -> dmem_req and mem_write_en drop asynchronously, state=0. Spurious imem_ack in IDLE -> no change.
